// File: rtl/code_patch_cfg_ctrl_if.sv
// code_patch_cfg_ctrl_if: request channel into the patch configuration sequencer
interface code_patch_cfg_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [IDX_WIDTH-1:0]  req_idx;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_nopg;
  logic                  req_gen;
  modport master (
    output req_valid, req_op, req_idx, req_addr, req_data, req_nopg, req_gen,
    input  req_ready
  );
  modport slave (
    input  req_valid, req_op, req_idx, req_addr, req_data, req_nopg, req_gen,
    output req_ready
  );
endinterface

// File: rtl/code_patch_cfg_ctrl.sv
// code_patch_cfg_ctrl: gated gate/drain/update/restore sequencer for the patch substitution registers
module code_patch_cfg_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 8,
  parameter int IDX_WIDTH     = 4,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  code_patch_cfg_ctrl_if.slave                 req,
  input  logic                                 si_read_i,
  output logic [NUM_REGS-1:0][ADDR_WIDTH-1:0]  ctl_pat_addr_o,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  ctl_pat_data_o,
  output logic [NUM_REGS-1:0]                  ctl_pat_pen_o,
  output logic [NUM_REGS-1:0]                  ctl_pat_nopg_o,
  output logic                                 cfg_pat_gen_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);
  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, GATE, DRAIN, UPDATE, RESTORE} state_e;
  state_e                              state_q;
  logic [CW-1:0]                       cnt_q;
  logic [1:0]                          op_q;
  logic [IDX_WIDTH-1:0]                idx_q;
  logic [ADDR_WIDTH-1:0]               addr_q;
  logic [DATA_WIDTH-1:0]               data_q;
  logic                                nopg_q;
  logic                                req_gen_q;
  logic [NUM_REGS-1:0][ADDR_WIDTH-1:0] pat_addr_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] pat_data_q;
  logic [NUM_REGS-1:0]                 pen_q;
  logic [NUM_REGS-1:0]                 pat_nopg_q;
  logic                                gen_en_q;
  logic                                gen_q;
  logic                                ready_q;
  logic                                busy_q;
  logic                                done_q;
  logic                                err_q;
  logic                                bad_idx;
  // index is widened by one bit so NUM_REGS == 2**IDX_WIDTH compares correctly
  assign bad_idx = !req.req_op[1] && ({1'b0, req.req_idx} >= (IDX_WIDTH+1)'(NUM_REGS));
  // sequencer: patch generation is held off while the bus drains, then the entry is committed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      nopg_q     <= 1'b0;
      req_gen_q  <= 1'b0;
      pat_addr_q <= '0;
      pat_data_q <= '0;
      pen_q      <= '0;
      pat_nopg_q <= '0;
      gen_en_q   <= 1'b0;
      gen_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (req.req_valid && ready_q) begin
          if (bad_idx) err_q <= 1'b1;
          else begin
            op_q      <= req.req_op;
            idx_q     <= req.req_idx;
            addr_q    <= req.req_addr;
            data_q    <= req.req_data;
            nopg_q    <= req.req_nopg;
            req_gen_q <= req.req_gen;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            gen_q     <= 1'b0;
            state_q   <= GATE;
          end
        end
        GATE: begin
          cnt_q   <= '0;
          state_q <= DRAIN;
        end
        DRAIN: if (!si_read_i) state_q <= UPDATE;
        else if (cnt_q == CW'(DRAIN_TIMEOUT - 1)) begin
          err_q   <= 1'b1;
          gen_q   <= gen_en_q;
          state_q <= RESTORE;
        end else cnt_q <= cnt_q + 1'b1;
        UPDATE: begin
          for (int i = 0; i < NUM_REGS; i++)
            if (op_q == 2'b10 || (!op_q[1] && IDX_WIDTH'(i) == idx_q)) begin
              pat_addr_q[i] <= op_q == 2'b00 ? addr_q : '0;
              pat_data_q[i] <= op_q == 2'b00 ? data_q : '0;
              pat_nopg_q[i] <= op_q == 2'b00 && nopg_q;
              pen_q[i]      <= op_q == 2'b00;
            end
          if (op_q == 2'b11) gen_en_q <= req_gen_q;
          gen_q   <= op_q == 2'b11 ? req_gen_q : gen_en_q;
          done_q  <= 1'b1;
          state_q <= RESTORE;
        end
        RESTORE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req.req_ready   = ready_q;
  assign ctl_pat_addr_o  = pat_addr_q;
  assign ctl_pat_data_o  = pat_data_q;
  assign ctl_pat_pen_o   = pen_q;
  assign ctl_pat_nopg_o  = pat_nopg_q;
  assign cfg_pat_gen_o   = gen_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
endmodule

// File: doc/code_patch_cfg_ctrl.md
Name: code_patch_cfg_ctrl

Overview:
- Configuration sequencer for the code-patch datapath. Owns the substitution register file: per-entry match address, substitute data, patch-enable and no-propagate bits, plus the global patch-generate enable. These feed the patch core's ctl_pat_* and cfg_pat_gen inputs.
- Accepts single update requests over a valid/ready handshake.
- Each update runs a gate → drain → update → restore sequence, so a bus read never sees a half-written entry.

Parameters:
- ADDR_WIDTH, 32, width of match address.
- DATA_WIDTH, 32, width of patch data entry.
- NUM_REGS, 8, number of substitution entries.
- IDX_WIDTH, 4, width of the entry index field. Must satisfy 2^IDX_WIDTH >= NUM_REGS.
- DRAIN_TIMEOUT, 16, maximum cycles spent waiting for the bus to go idle.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- req_op_i  in  2  operation: 00 write entry, 01 clear entry, 10 clear all, 11 set global enable.
- req_idx_i  in  IDX_WIDTH  target entry (ops 00/01).
- req_addr_i  in  ADDR_WIDTH  match address (op 00).
- req_data_i  in  DATA_WIDTH  substitute data (op 00).
- req_nopg_i  in  1  no-propagate bit (op 00).
- req_gen_i  in  1  new global enable value (op 11).
- si_read_i  in  1  read transaction currently on slave bus.
- ctl_pat_addr_o  out  ADDR_WIDTH x NUM_REGS  entry match addresses.
- ctl_pat_data_o  out  DATA_WIDTH x NUM_REGS  entry data.
- ctl_pat_pen_o  out  NUM_REGS  entry enables.
- ctl_pat_nopg_o  out  NUM_REGS  entry no-propagate bits.
- cfg_pat_gen_o  out  1  effective global enable to patch core.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse: update committed.
- err_o  out  1  one-cycle pulse: bad index or drain timeout.

Behaviour:
- Reset: all entry arrays 0; pen/nopg 0; internal gen_en 0; cfg_pat_gen_o 0; req_ready_o 1; busy_o, done_o, err_o 0; FSM to IDLE; drain counter 0.
  - Reset mid-sequence aborts with no entry change and no done/err pulse.
- Handshake:
  - req_ready_o = 1 only in IDLE.
  - A request is accepted on the rising edge where req_valid_i & req_ready_o.
  - Request fields are captured into holding registers at accept; inputs may change afterwards.
- Index check: op 00/01 with req_idx_i >= NUM_REGS → err_o pulses the cycle after accept, FSM stays IDLE, no state changes.
- FSM states: IDLE, GATE, DRAIN, UPDATE, RESTORE.
  - IDLE → GATE on a valid accept.
  - GATE: cfg_pat_gen_o forced 0; drain counter cleared; → DRAIN next cycle.
  - DRAIN:
    - si_read_i == 0 → UPDATE.
    - Otherwise counter increments.
    - When counter == DRAIN_TIMEOUT-1 and si_read_i still 1 → RESTORE with error flag; no write.
  - UPDATE, single cycle, performs the op:
    - 00: addr/data/nopg[idx] loaded, pen[idx] = 1.
    - 01: pen[idx] = 0; addr/data/nopg[idx] = 0.
    - 10: all entries and bits zeroed.
    - 11: gen_en = req_gen_i.
    - → RESTORE.
  - RESTORE:
    - cfg_pat_gen_o = gen_en from this cycle on.
    - done_o pulses on success; err_o pulses on timeout.
    - → IDLE.
- cfg_pat_gen_o = gen_en whenever the state is not GATE, DRAIN or UPDATE; it is 0 in those three states.
- busy_o = 1 in GATE, DRAIN, UPDATE and RESTORE.
- Latency with an idle bus: accept at edge T; GATE T..T+1, DRAIN T+1..T+2, UPDATE T+2..T+3. New entry values are visible after edge T+3; done_o is high in cycle T+3..T+4; req_ready_o returns 1 at T+4.
- Outputs ctl_pat_* and cfg_pat_gen_o are registered; there is no combinational path from req_* to them.
- Entries not addressed by an op retain their value.

Test Plan:
- Write entry: op00 idx=3 addr=0x0000_1000 data=0x0000_2000 nopg=1, si_read_i=0 → 4 cycles later ctl_pat_addr_o[3]=0x1000, data[3]=0x2000, pen=0x08, nopg=0x08; done_o one pulse; other entries 0.
- Gating: gen_en=1, then op00 idx=0 → cfg_pat_gen_o goes 0 in GATE/DRAIN/UPDATE and returns 1 in RESTORE; req_ready_o low for exactly 4 cycles.
- Drain wait: si_read_i held 1 for 5 cycles after GATE, then 0 → UPDATE occurs the cycle after si_read_i falls; done_o pulses; entry written.
- Timeout: si_read_i held 1 permanently, DRAIN_TIMEOUT=16 → after 16 DRAIN cycles err_o pulses; entry unchanged; cfg_pat_gen_o restored to prior value; done_o never asserts.
- Bad index: op00 idx=9 with NUM_REGS=8 → err_o pulse next cycle; busy_o stays 0; no array change.
- Clear-all plus reset: load idx 0..7, issue op10 → pen=0x00, all arrays 0. Separately, assert rst_i during DRAIN → all outputs return to reset values next cycle and req_ready_o=1.
